// File: rtl/alu_pkg.sv
// Shared ALU constants and elaboration helpers for the pipelined result mux.
package alu_pkg;

  localparam int ALU_WIDTH     = 16;
  localparam int ALU_NUM_FUNCS = 16;

  // ALU function-select encoding; these values drive the result mux select.
  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_MUL   = 4'd10,
    ALU_MULH  = 4'd11,
    ALU_PASSA = 4'd12,
    ALU_PASSB = 4'd13,
    ALU_NOT   = 4'd14,
    ALU_NOP   = 4'd15
  } alu_func_e;

  // Number of RADIX:1 levels needed to cover n inputs (at least one).
  function automatic int mux_levels(int n, int r);
    int span = 1;
    int lv   = 0;
    for (int i = 0; i < 16; i++) begin
      if (span < n) begin
        span = span * r;
        lv++;
      end
    end
    return (lv == 0) ? 1 : lv;
  endfunction

  // Word count entering level lvl (level 0 = raw inputs).
  function automatic int node_cnt(int n, int r, int lvl);
    int c = n;
    for (int i = 0; i < lvl; i++) c = (c + r - 1) / r;
    return c;
  endfunction

  // Word offset of level lvl inside the flattened data chain.
  function automatic int data_off(int n, int r, int lvl);
    int o = 0;
    for (int i = 0; i < lvl; i++) o += node_cnt(n, r, i);
    return o;
  endfunction

  // Tag = {remaining select bits, err}; it shrinks by rb bits per level.
  function automatic int tag_w(int levels, int rb, int lvl);
    return (levels - lvl) * rb + 1;
  endfunction

  // Bit offset of level lvl inside the flattened tag chain.
  function automatic int tag_off(int levels, int rb, int lvl);
    int o = 0;
    for (int i = 0; i < lvl; i++) o += tag_w(levels, rb, i);
    return o;
  endfunction

endpackage

// File: rtl/pipelined_select_mux_if.sv
// Stream bus of the result mux: producer side (in_*) and consumer side (out_*).
interface pipelined_select_mux_if #(
  parameter int WIDTH  = 16,
  parameter int NUM_IN = 16
);
  localparam int SEL_W = $clog2(NUM_IN);

  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]        in_sel;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_err;
  logic                    out_valid;
  logic                    out_ready;

  // Environment side: drives requests, consumes results.
  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_err, out_valid
  );

  // Mux side.
  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_err, out_valid
  );
endinterface

// File: rtl/mux_stage.sv
// One registered RADIX:1 tree level. Consumes the low select bits of the tag,
// forwards the remaining select bits and the err flag with the data.
module mux_stage #(
  parameter int WIDTH    = 16,
  parameter int IN_CNT   = 16,
  parameter int RADIX    = 4,
  parameter int TAG_IN_W = 5
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         in_valid,
  output logic                                         in_ready,
  input  logic [IN_CNT*WIDTH-1:0]                      in_data,
  input  logic [TAG_IN_W-1:0]                          in_tag,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic [((IN_CNT+RADIX-1)/RADIX)*WIDTH-1:0]    out_data,
  output logic [TAG_IN_W-$clog2(RADIX)-1:0]            out_tag
);
  localparam int RB        = $clog2(RADIX);
  localparam int OUT_CNT   = (IN_CNT + RADIX - 1) / RADIX;
  localparam int PAD_CNT   = OUT_CNT * RADIX;
  localparam int TAG_OUT_W = TAG_IN_W - RB;

  logic [PAD_CNT-1:0][WIDTH-1:0] in_pad;
  logic [OUT_CNT-1:0][WIDTH-1:0] mux_nxt, dat_q;
  logic [RB-1:0]                 idx;
  logic [TAG_OUT_W-1:0]          tag_nxt, tag_q;
  logic                          vld_q, load;

  // Tag bit 0 is err; the next RB bits pick within each group.
  assign idx      = in_tag[RB:1];
  assign load     = !vld_q || out_ready;
  assign in_ready = load;

  // Missing inputs of the last group read as zero, so out-of-range selects land on 0.
  for (genvar i = 0; i < PAD_CNT; i++) begin : g_pad
    if (i < IN_CNT) begin : g_in
      assign in_pad[i] = in_data[i*WIDTH +: WIDTH];
    end else begin : g_zero
      assign in_pad[i] = '0;
    end
  end

  for (genvar k = 0; k < OUT_CNT; k++) begin : g_node
    logic [RADIX-1:0][WIDTH-1:0] grp;
    assign grp        = in_pad[k*RADIX +: RADIX];
    assign mux_nxt[k] = grp[idx];
  end

  if (TAG_OUT_W > 1) begin : g_tag_fwd
    assign tag_nxt = {in_tag[TAG_IN_W-1:RB+1], in_tag[0]};
  end else begin : g_tag_last
    assign tag_nxt = in_tag[0];
  end

  // Stage valid: cleared by reset, reloaded whenever the stage can advance.
  always_ff @(posedge clk) begin
    if (rst)       vld_q <= 1'b0;
    else if (load) vld_q <= in_valid;
  end

  // Payload only changes on an actual load; held otherwise (don't-care when empty).
  always_ff @(posedge clk) begin
    if (load && in_valid) begin
      dat_q <= mux_nxt;
      tag_q <= tag_nxt;
    end
  end

  assign out_valid = vld_q;
  assign out_data  = dat_q;
  assign out_tag   = tag_q;
endmodule

// File: rtl/pipelined_select_mux.sv
// Registered N:1 select mux built as a chain of mux_stage levels with a
// valid/ready handshake. Level data/tags live in flat chains so every level
// can have its own width without unused padding.
module pipelined_select_mux
  import alu_pkg::*;
#(
  parameter int WIDTH  = ALU_WIDTH,
  parameter int NUM_IN = ALU_NUM_FUNCS,
  parameter int RADIX  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  pipelined_select_mux_if.slave bus
);
  localparam int SEL_W   = $clog2(NUM_IN);
  localparam int RB      = $clog2(RADIX);
  localparam int LEVELS  = mux_levels(NUM_IN, RADIX);
  localparam int SW_TOT  = LEVELS * RB;
  localparam int DAT_TOT = data_off(NUM_IN, RADIX, LEVELS + 1);
  localparam int TAG_TOT = tag_off(LEVELS, RB, LEVELS + 1);
  localparam int DO_LAST = data_off(NUM_IN, RADIX, LEVELS);
  localparam int TO_LAST = tag_off(LEVELS, RB, LEVELS);

  logic [DAT_TOT*WIDTH-1:0] dat_chain;
  logic [TAG_TOT-1:0]       tag_chain;
  logic [LEVELS:0]          vld_pipe, rdy_pipe;
  logic [SEL_W-1:0]         sel;
  logic                     sel_err;
  logic                     last_err;
  logic [WIDTH-1:0]         last_dat;

  assign sel     = bus.in_sel;
  assign sel_err = 32'(sel) >= NUM_IN;

  // Level 0 feeds raw inputs; select zero-extended to the bits all levels consume.
  assign dat_chain[NUM_IN*WIDTH-1:0] = bus.in_data;
  assign tag_chain[SW_TOT:0]         = {SW_TOT'(sel), sel_err};
  assign vld_pipe[0]                 = bus.in_valid;
  assign rdy_pipe[LEVELS]            = bus.out_ready;
  assign bus.in_ready                = rdy_pipe[0];

  for (genvar j = 0; j < LEVELS; j++) begin : g_lvl
    localparam int IC   = node_cnt(NUM_IN, RADIX, j);
    localparam int OC   = node_cnt(NUM_IN, RADIX, j + 1);
    localparam int DO_I = data_off(NUM_IN, RADIX, j);
    localparam int DO_O = data_off(NUM_IN, RADIX, j + 1);
    localparam int TW_I = tag_w(LEVELS, RB, j);
    localparam int TW_O = tag_w(LEVELS, RB, j + 1);
    localparam int TO_I = tag_off(LEVELS, RB, j);
    localparam int TO_O = tag_off(LEVELS, RB, j + 1);

    mux_stage #(
      .WIDTH   (WIDTH),
      .IN_CNT  (IC),
      .RADIX   (RADIX),
      .TAG_IN_W(TW_I)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .in_valid (vld_pipe[j]),
      .in_ready (rdy_pipe[j]),
      .in_data  (dat_chain[DO_I*WIDTH +: IC*WIDTH]),
      .in_tag   (tag_chain[TO_I +: TW_I]),
      .out_valid(vld_pipe[j+1]),
      .out_ready(rdy_pipe[j+1]),
      .out_data (dat_chain[DO_O*WIDTH +: OC*WIDTH]),
      .out_tag  (tag_chain[TO_O +: TW_O])
    );
  end

  assign last_dat = dat_chain[DO_LAST*WIDTH +: WIDTH];
  assign last_err = tag_chain[TO_LAST];

  // Outputs read zero when empty; an errored beat always carries zero data.
  assign bus.out_valid = vld_pipe[LEVELS];
  assign bus.out_err   = vld_pipe[LEVELS] && last_err;
  assign bus.out_data  = (vld_pipe[LEVELS] && !last_err) ? last_dat : '0;
endmodule

// File: tb/tb_pipelined_select_mux.sv
// Directed bench for pipelined_select_mux: default config (A), NUM_IN=12 (B),
// RADIX=2/NUM_IN=5/WIDTH=32 (C), plus a randomized scoreboard run on A.
module tb_pipelined_select_mux;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipelined_select_mux_if #(.WIDTH(16), .NUM_IN(16)) ifa ();
  pipelined_select_mux_if #(.WIDTH(16), .NUM_IN(12)) ifb ();
  pipelined_select_mux_if #(.WIDTH(32), .NUM_IN(5))  ifc ();

  pipelined_select_mux #(.WIDTH(16), .NUM_IN(16), .RADIX(4)) u_dut_a (.clk(clk), .rst(rst), .bus(ifa));
  pipelined_select_mux #(.WIDTH(16), .NUM_IN(12), .RADIX(4)) u_dut_b (.clk(clk), .rst(rst), .bus(ifb));
  pipelined_select_mux #(.WIDTH(32), .NUM_IN(5),  .RADIX(2)) u_dut_c (.clk(clk), .rst(rst), .bus(ifc));

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Directed tables
  int          bp_sel [4] = '{3, 7, 12, 15};
  logic [15:0] bp_exp [4] = '{16'hA003, 16'hA007, 16'hA00C, 16'hA00F};
  int          b_sel  [5] = '{13, 11, 0, 12, 15};
  logic [15:0] b_dat  [5] = '{16'h0000, 16'hB00B, 16'hB000, 16'h0000, 16'h0000};
  logic        b_err  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [31:0] c_word [5] = '{32'hDEAD_0000, 32'hBEEF_0001, 32'hCAFE_0002, 32'hF00D_0003, 32'h1234_0004};
  logic [31:0] c_dat  [8] = '{32'hDEAD_0000, 32'hBEEF_0001, 32'hCAFE_0002, 32'hF00D_0003,
                              32'h1234_0004, 32'h0, 32'h0, 32'h0};
  logic        c_err  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  int idx, oidx, stall, nstall, sent, rcvd;
  bit seen, acc, prev_stall;
  logic [16:0] prev_word, exp_word;
  logic [15:0] sb_q [$];

  initial begin
    rst = 1'b1;
    ifa.in_valid = 0; ifa.in_sel = '0; ifa.out_ready = 1;
    ifb.in_valid = 0; ifb.in_sel = '0; ifb.out_ready = 1;
    ifc.in_valid = 0; ifc.in_sel = '0; ifc.out_ready = 1;
    for (int k = 0; k < 16; k++) ifa.in_data[k*16 +: 16] = 16'hA000 + 16'(k);
    for (int k = 0; k < 12; k++) ifb.in_data[k*16 +: 16] = 16'hB000 + 16'(k);
    for (int k = 0; k < 5; k++)  ifc.in_data[k*32 +: 32] = c_word[k];

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_vld",  ifa.out_valid, 0);
    chk("rst_data", ifa.out_data, 0);
    chk("rst_err",  ifa.out_err, 0);
    chk("rst_rdy",  ifa.in_ready, 1);
    chk("rst_vld_c", ifc.out_valid, 0);
    @(posedge clk); #1;

    // 1: back-to-back sweep, latency 2, one result per cycle
    for (int c = 0; c < 19; c++) begin
      ifa.in_valid = (c < 16);
      ifa.in_sel   = 4'(c);
      @(negedge clk);
      chk("t1_rdy", ifa.in_ready, 1);
      chk("t1_vld", ifa.out_valid, (c >= 2 && c < 18));
      if (c >= 2 && c < 18) begin
        chk("t1_data", ifa.out_data, 16'hA000 + 16'(c - 2));
        chk("t1_err",  ifa.out_err, 0);
      end else begin
        chk("t1_idle", ifa.out_data, 0);
      end
      @(posedge clk); #1;
    end
    ifa.in_valid = 0;

    // 2: backpressure, 5 stalled cycles after the first result
    idx = 0; oidx = 0; stall = 0; nstall = 0; seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (ifa.out_valid && !seen) begin seen = 1; stall = 5; end
      ifa.out_ready = (stall == 0);
      if (stall > 0) stall--;
      ifa.in_valid = (idx < 4);
      ifa.in_sel   = 4'(bp_sel[(idx < 4) ? idx : 0]);
      @(negedge clk);
      if (ifa.out_valid && !ifa.out_ready) begin
        nstall++;
        chk("t2_hold",  ifa.out_data, 16'hA003);
        chk("t2_inrdy", ifa.in_ready, 0);
      end
      acc = ifa.in_valid && ifa.in_ready;
      if (ifa.out_valid && ifa.out_ready) begin
        chk("t2_data", ifa.out_data, (oidx < 4) ? bp_exp[oidx] : 16'hFFFF);
        chk("t2_err",  ifa.out_err, 0);
        oidx++;
      end
      if (acc) idx++;
      @(posedge clk); #1;
    end
    chk("t2_count",  oidx, 4);
    chk("t2_stalls", nstall, 5);
    ifa.in_valid = 0; ifa.out_ready = 1;

    // 3: NUM_IN=12, out-of-range selects flagged per beat
    for (int c = 0; c < 8; c++) begin
      ifb.in_valid = (c < 5);
      ifb.in_sel   = 4'(b_sel[(c < 5) ? c : 0]);
      @(negedge clk);
      chk("t3_vld", ifb.out_valid, (c >= 2 && c < 7));
      if (c >= 2 && c < 7) begin
        chk("t3_data", ifb.out_data, b_dat[c-2]);
        chk("t3_err",  ifb.out_err, b_err[c-2]);
      end
      @(posedge clk); #1;
    end
    ifb.in_valid = 0;

    // 4: reset with two transfers in flight
    ifa.out_ready = 0;
    ifa.in_valid = 1; ifa.in_sel = 4'd1;
    @(negedge clk); chk("t4_rdy0", ifa.in_ready, 1);
    @(posedge clk); #1;
    ifa.in_sel = 4'd2;
    @(negedge clk); chk("t4_rdy1", ifa.in_ready, 1);
    @(posedge clk); #1;
    rst = 1; ifa.in_sel = 4'd5;
    @(negedge clk);
    chk("t4_full_v", ifa.out_valid, 1);
    chk("t4_full_d", ifa.out_data, 16'hA001);
    @(posedge clk); #1;
    rst = 0; ifa.in_valid = 0; ifa.out_ready = 1;
    @(negedge clk);
    chk("t4_vld",  ifa.out_valid, 0);
    chk("t4_data", ifa.out_data, 0);
    chk("t4_rdy",  ifa.in_ready, 1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("t4_gone", ifa.out_valid, 0);
    end
    @(posedge clk); #1;

    // 5: RADIX=2, NUM_IN=5, WIDTH=32 -> three levels
    for (int c = 0; c < 11; c++) begin
      ifc.in_valid = (c < 8);
      ifc.in_sel   = 3'(c);
      @(negedge clk);
      chk("t5_vld", ifc.out_valid, (c >= 3 && c < 11));
      if (c >= 3) begin
        chk("t5_data", ifc.out_data, c_dat[c-3]);
        chk("t5_err",  ifc.out_err, c_err[c-3]);
      end
      @(posedge clk); #1;
    end
    ifc.in_valid = 0;

    // 6: random handshakes against an in-order scoreboard
    sent = 0; rcvd = 0; prev_stall = 0; prev_word = '0;
    sb_q.delete();
    for (int c = 0; c < 20000 && rcvd < 1000; c++) begin
      ifa.in_valid  = (sent < 1000) && ($urandom_range(1, 0) == 1);
      ifa.in_sel    = 4'($urandom_range(15, 0));
      ifa.out_ready = ($urandom_range(1, 0) == 1);
      @(negedge clk);
      if (prev_stall) begin
        chk("t6_hold_v", ifa.out_valid, 1);
        chk("t6_hold_d", {ifa.out_err, ifa.out_data}, prev_word);
      end
      if (ifa.in_valid && ifa.in_ready) begin
        sb_q.push_back(16'hA000 + 16'(ifa.in_sel));
        sent++;
      end
      if (ifa.out_valid && ifa.out_ready) begin
        exp_word = 17'h1FFFF;
        if (sb_q.size() > 0) exp_word = {1'b0, sb_q.pop_front()};
        chk("t6_data", {ifa.out_err, ifa.out_data}, exp_word);
        rcvd++;
      end
      prev_stall = ifa.out_valid && !ifa.out_ready;
      prev_word  = {ifa.out_err, ifa.out_data};
      @(posedge clk); #1;
    end
    chk("t6_rcvd",  rcvd, 1000);
    chk("t6_empty", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/pipelined_select_mux.md
Name: pipelined_select_mux

Overview:
- Parametrised, registered N:1 select mux with a valid/ready stream handshake. It replaces the fixed combinational 16-bit, 16-input ALU result mux.
- It is built as a tree of RADIX:1 levels, with a register after every level. This keeps the select path off the ALU critical path, and the pipeline can stall under downstream backpressure.
- It sits between the ALU function units (producers) and the writeback/forwarding logic (consumer).

Parameters:
- WIDTH, 16, data bits per input.
- NUM_IN, 16, number of selectable inputs (2..256).
- RADIX, 4, inputs per mux node at each level (2 or 4).
- SEL_W, clog2(NUM_IN), select width. This is derived and must not be overridden.
- LEVELS, ceil(log_RADIX(NUM_IN)), number of pipeline levels. This is derived.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  NUM_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
- in_sel  in  SEL_W  input index to forward.
- in_valid  in  1  in_data/in_sel are valid this cycle.
- in_ready  out  1  the block accepts a transfer this cycle.
- out_data  out  WIDTH  selected word.
- out_err  out  1  the transfer carried an out-of-range select (in_sel >= NUM_IN).
- out_valid  out  1  out_data/out_err are valid.
- out_ready  in  1  the consumer accepts a transfer this cycle.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - All stage valid bits clear, so out_valid=0.
  - out_data=0, out_err=0.
  - in_ready=1 in the first cycle after rst deasserts.
- Transfers:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
- Tree structure:
  - Level 0 partitions the NUM_IN inputs into groups of RADIX and selects within each group using the low log2(RADIX) bits of in_sel.
  - Each level j uses the next log2(RADIX) select bits.
  - Missing inputs are padded with zero when NUM_IN is not a power of RADIX.
- Per-level register: stage j holds valid[j], the partial results, the remaining select bits and the err flag.
  - Stage j advances (load) when ready[j] = !valid[j] | ready[j+1].
  - ready[LEVELS] = out_ready.
  - in_ready = ready[0], which is combinational from out_ready through the stage valids. No skid buffer is used.
- Latency: an accepted transfer appears on out_valid exactly LEVELS cycles later when no stall occurs (2 for the defaults). Throughput is 1 per cycle under continuous out_ready=1.
- Stall: while out_ready=0 and out_valid=1, out_data and out_err are held stable. Upstream stages fill until in_ready drops. No data is lost or duplicated.
- Out-of-range select: if in_sel >= NUM_IN, out_data=0 and out_err=1 for that transfer only. The flag travels with the data through the pipeline.
- Data of a stage that is not loading is held. When valid[j]=0, the register contents are don't-care, but out_data must read 0 while out_valid=0.
- Reset mid-operation: rst clears all valid bits in the same cycle, so in-flight transfers are discarded. in_ready is ignored during rst, and no transfer is accepted on a cycle with rst=1.
- Simultaneous events: a stage may unload and reload in the same cycle (full throughput). Pipeline order is strictly FIFO.

Decomposition:
- Shared package (alu_pkg): ALU_WIDTH=16, ALU_NUM_FUNCS=16, and the ALU function-select encoding constants used to drive in_sel. A clog2 helper function also goes in the package if the toolchain lacks $clog2.
- Sub-module mux_stage (parameters WIDTH, IN_CNT, RADIX): one registered tree level with the valid/ready/sel/err pass-through. pipelined_select_mux generates LEVELS instances of it.

Test Plan:
1. Defaults; input k = 16'hA000+k; sweep in_sel 0..15 back-to-back with out_ready=1 -> out_data A000..A00F in order; first out_valid exactly 2 cycles after the first accept; one result per cycle thereafter; out_err=0.
2. Backpressure: stream sel 3,7,12,15; hold out_ready=0 for 5 cycles after the first out_valid -> out_data holds A003; in_ready drops once both stages are full; after release, A007, A00C, A00F follow with no loss or duplication.
3. NUM_IN=12, RADIX=4; in_sel=13 -> out_data=0, out_err=1 for that beat only. A following in_sel=11 -> out_data=input 11, out_err=0.
4. Reset mid-flight: accept 2 transfers, assert rst for 1 cycle -> out_valid=0 the next cycle, neither result ever emerges, and in_ready=1 after rst deasserts.
5. RADIX=2, NUM_IN=5, WIDTH=32 -> LEVELS=3; every sel 0..4 returns the correct word with 3-cycle latency; sel 5..7 -> err=1.
6. Random in_valid/out_ready (50%), 1000 transfers, checked against a scoreboard model -> exact ordered match; out_data/out_err stable whenever out_valid & !out_ready.
